cpu_bus_ctrl: RTL and testbench

Memory-side bus controller directly downstream of the Cpu core.
- Consumes the core's req_rdwr / which_rdwr / addr / data_out.
- Runs one read or write on a simple synchronous memory port, with programmable wait states and a ready handshake.
- Stalls the core through its enable input and returns read data on its data_in input.
- A bus timeout aborts hung accesses and flags an error.

---
 rtl/cpu_bus_ctrl.sv | 109 ++++++++++
 tb/tb_cpu_bus_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_ctrl.sv
// Memory-side bus controller for the Cpu core: turns one core request into a single
// strobed memory access with wait states, a ready handshake and a timeout abort.
module cpu_bus_ctrl #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int WAIT_STATES = 2,
  parameter int TIMEOUT     = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req_rdwr,
  input  logic                  cpu_which_rdwr,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_data_out,
  output logic                  cpu_enable,
  output logic [DATA_WIDTH-1:0] cpu_data_in,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_re,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic                  bus_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] WAIT_INIT   = 4'(WAIT_STATES);
  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT);

  state_t     state;
  logic       is_write;
  logic [3:0] wait_cnt;
  logic [7:0] to_cnt;

  // Ready is checked before the timeout limit, so a late ready on the final cycle still completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      is_write    <= 1'b0;
      wait_cnt    <= '0;
      to_cnt      <= '0;
      cpu_enable  <= 1'b1;
      cpu_data_in <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_re      <= 1'b0;
      mem_we      <= 1'b0;
      bus_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cpu_enable <= 1'b1;
          bus_err    <= 1'b0;
          if (cpu_req_rdwr) begin
            mem_addr <= cpu_addr;
            if (cpu_which_rdwr) begin
              mem_wdata <= cpu_data_out;
            end
            is_write   <= cpu_which_rdwr;
            mem_re     <= ~cpu_which_rdwr;
            mem_we     <= cpu_which_rdwr;
            cpu_enable <= 1'b0;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          mem_re   <= 1'b0;
          mem_we   <= 1'b0;
          wait_cnt <= WAIT_INIT;
          to_cnt   <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else if (mem_ready) begin
            if (!is_write) begin
              cpu_data_in <= mem_rdata;
            end
            cpu_enable <= 1'b1;
            state      <= DONE;
          end else if (to_cnt == TIMEOUT_LIM) begin
            if (!is_write) begin
              cpu_data_in <= '1;
            end
            bus_err    <= 1'b1;
            cpu_enable <= 1'b1;
            state      <= DONE;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
        end
        DONE: begin
          cpu_enable <= 1'b1;
          bus_err    <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_bus_ctrl.sv
// Directed self-checking bench for cpu_bus_ctrl: one instance with two wait states,
// a second with none; shared stimulus, request steered by sel.
module tb_cpu_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        which = 1'b0;
  logic [15:0] addr = '0;
  logic [7:0]  wdata = '0;
  logic [7:0]  rdata = '0;
  logic        ready = 1'b0;
  logic        sel = 1'b0;

  logic        en_a, re_a, we_a, err_a, en_b, re_b, we_b, err_b;
  logic [7:0]  din_a, mwd_a, din_b, mwd_b;
  logic [15:0] maddr_a, maddr_b;
  logic        en, re, we, err;
  logic [7:0]  din, mwd;
  logic [15:0] maddr;

  int total = 0;
  int bad = 0;

  cpu_bus_ctrl #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .WAIT_STATES(2), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .cpu_req_rdwr(req & ~sel), .cpu_which_rdwr(which),
    .cpu_addr(addr), .cpu_data_out(wdata), .cpu_enable(en_a), .cpu_data_in(din_a),
    .mem_addr(maddr_a), .mem_wdata(mwd_a), .mem_re(re_a), .mem_we(we_a),
    .mem_rdata(rdata), .mem_ready(ready), .bus_err(err_a));

  cpu_bus_ctrl #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .WAIT_STATES(0), .TIMEOUT(15)) dut_ws0 (
    .clk(clk), .rst(rst), .cpu_req_rdwr(req & sel), .cpu_which_rdwr(which),
    .cpu_addr(addr), .cpu_data_out(wdata), .cpu_enable(en_b), .cpu_data_in(din_b),
    .mem_addr(maddr_b), .mem_wdata(mwd_b), .mem_re(re_b), .mem_we(we_b),
    .mem_rdata(rdata), .mem_ready(ready), .bus_err(err_b));

  assign en    = sel ? en_b    : en_a;
  assign re    = sel ? re_b    : re_a;
  assign we    = sel ? we_b    : we_a;
  assign err   = sel ? err_b   : err_a;
  assign din   = sel ? din_b   : din_a;
  assign mwd   = sel ? mwd_b   : mwd_a;
  assign maddr = sel ? maddr_b : maddr_a;

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issues one request and measures it; ready is raised after sample index ready_at (-1 = never).
  task automatic do_access(input logic w, input logic [15:0] a, input logic [7:0] d,
                           input int ready_at, output int low, output int re_n,
                           output int we_n, output int err_n, output logic [7:0] din_done,
                           output logic [15:0] addr_s, output logic [7:0] wd_s);
    int idx;
    which = w; addr = a; wdata = d; ready = 1'b0; req = 1'b1;
    tick;
    req = 1'b0;
    addr_s = maddr; wd_s = mwd;
    low = 0; re_n = 0; we_n = 0; err_n = 0; idx = 0;
    while (!en && idx < 200) begin
      low++; re_n += int'(re); we_n += int'(we); err_n += int'(err);
      if (idx == ready_at) ready = 1'b1;
      tick;
      idx++;
    end
    din_done = din;
    for (int i = 0; i < 3; i++) begin
      re_n += int'(re); we_n += int'(we); err_n += int'(err);
      if (i < 2) tick;
    end
    ready = 1'b0;
  endtask

  task automatic test_reset;
    #2 rst = 1'b0;
    #1;
    total++; if (en !== 1'b1) begin bad++; $display("FAIL reset_en got=%b want=1", en); end
    total++; if (din !== 8'h00) begin bad++; $display("FAIL reset_din got=%h want=00", din); end
    total++; if (maddr !== 16'h0000) begin bad++; $display("FAIL reset_addr got=%h want=0000", maddr); end
    total++; if (mwd !== 8'h00) begin bad++; $display("FAIL reset_wdata got=%h want=00", mwd); end
    total++; if ({re, we, err} !== 3'b000) begin bad++; $display("FAIL reset_strobes got=%b want=000", {re, we, err}); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    tick;
  endtask

  task automatic test_read;
    int low, re_n, we_n, err_n; logic [7:0] dd, wd; logic [15:0] as;
    sel = 1'b0; rdata = 8'hA5;
    do_access(1'b0, 16'h1234, 8'h00, 0, low, re_n, we_n, err_n, dd, as, wd);
    total++; if (re_n !== 1) begin bad++; $display("FAIL read_re_count got=%0d want=1", re_n); end
    total++; if (we_n !== 0) begin bad++; $display("FAIL read_we_count got=%0d want=0", we_n); end
    total++; if (as !== 16'h1234) begin bad++; $display("FAIL read_addr got=%h want=1234", as); end
    total++; if (low !== 4) begin bad++; $display("FAIL read_stall got=%0d want=4", low); end
    total++; if (dd !== 8'hA5) begin bad++; $display("FAIL read_data got=%h want=a5", dd); end
    total++; if (err_n !== 0) begin bad++; $display("FAIL read_err got=%0d want=0", err_n); end
  endtask

  task automatic test_write;
    int low, re_n, we_n, err_n; logic [7:0] dd, wd; logic [15:0] as;
    sel = 1'b1; rdata = 8'h5A;
    do_access(1'b0, 16'h0010, 8'h00, 0, low, re_n, we_n, err_n, dd, as, wd);
    total++; if (dd !== 8'h5A) begin bad++; $display("FAIL ws0_read_data got=%h want=5a", dd); end
    total++; if (low !== 2) begin bad++; $display("FAIL ws0_read_stall got=%0d want=2", low); end
    rdata = 8'hEE;
    do_access(1'b1, 16'h00FF, 8'h3C, 0, low, re_n, we_n, err_n, dd, as, wd);
    total++; if (we_n !== 1) begin bad++; $display("FAIL write_we_count got=%0d want=1", we_n); end
    total++; if (re_n !== 0) begin bad++; $display("FAIL write_re_count got=%0d want=0", re_n); end
    total++; if (wd !== 8'h3C) begin bad++; $display("FAIL write_wdata got=%h want=3c", wd); end
    total++; if (as !== 16'h00FF) begin bad++; $display("FAIL write_addr got=%h want=00ff", as); end
    total++; if (low !== 2) begin bad++; $display("FAIL write_stall got=%0d want=2", low); end
    total++; if (dd !== 8'h5A) begin bad++; $display("FAIL write_din_kept got=%h want=5a", dd); end
    total++; if (mwd !== 8'h3C) begin bad++; $display("FAIL write_wdata_held got=%h want=3c", mwd); end
    sel = 1'b0;
  endtask

  task automatic test_late_ready;
    int low, re_n, we_n, err_n; logic [7:0] dd, wd; logic [15:0] as;
    rdata = 8'h69;
    do_access(1'b0, 16'h0A0A, 8'h00, 8, low, re_n, we_n, err_n, dd, as, wd);
    total++; if (low !== 9) begin bad++; $display("FAIL late_stall got=%0d want=9", low); end
    total++; if (dd !== 8'h69) begin bad++; $display("FAIL late_data got=%h want=69", dd); end
    total++; if (err_n !== 0) begin bad++; $display("FAIL late_err got=%0d want=0", err_n); end
  endtask

  task automatic test_timeout;
    int low, re_n, we_n, err_n; logic [7:0] dd, wd; logic [15:0] as;
    rdata = 8'h11;
    do_access(1'b0, 16'hDEAD, 8'h00, -1, low, re_n, we_n, err_n, dd, as, wd);
    total++; if (low !== 19) begin bad++; $display("FAIL timeout_stall got=%0d want=19", low); end
    total++; if (dd !== 8'hFF) begin bad++; $display("FAIL timeout_data got=%h want=ff", dd); end
    total++; if (err_n !== 1) begin bad++; $display("FAIL timeout_err_pulses got=%0d want=1", err_n); end
    // Ready arriving on the very cycle the limit is hit must complete normally.
    rdata = 8'hC3;
    do_access(1'b0, 16'hBEEF, 8'h00, 18, low, re_n, we_n, err_n, dd, as, wd);
    total++; if (low !== 19) begin bad++; $display("FAIL ready_wins_stall got=%0d want=19", low); end
    total++; if (dd !== 8'hC3) begin bad++; $display("FAIL ready_wins_data got=%h want=c3", dd); end
    total++; if (err_n !== 0) begin bad++; $display("FAIL ready_wins_err got=%0d want=0", err_n); end
  endtask

  task automatic test_back_to_back;
    int n_re, n_we, first, second;
    logic [15:0] second_addr;
    n_re = 0; n_we = 0; first = -1; second = -1; second_addr = '0;
    which = 1'b0; addr = 16'h1111; rdata = 8'h12; ready = 1'b1; req = 1'b1;
    tick;
    for (int i = 0; i <= 10; i++) begin
      if (re) begin
        n_re++;
        if (first < 0) first = i;
        else if (second < 0) begin second = i; second_addr = maddr; end
      end
      n_we += int'(we);
      if (i == 0) addr = 16'h2222;
      if (i < 10) tick;
    end
    req = 1'b0;
    tick; tick; tick;
    ready = 1'b0;
    total++; if (n_re !== 2) begin bad++; $display("FAIL b2b_strobes got=%0d want=2", n_re); end
    total++; if (n_we !== 0) begin bad++; $display("FAIL b2b_we got=%0d want=0", n_we); end
    total++; if (first !== 0) begin bad++; $display("FAIL b2b_first got=%0d want=0", first); end
    total++; if (second !== 6) begin bad++; $display("FAIL b2b_spacing got=%0d want=6", second); end
    total++; if (second_addr !== 16'h2222) begin bad++; $display("FAIL b2b_addr got=%h want=2222", second_addr); end
    total++; if (en !== 1'b1) begin bad++; $display("FAIL b2b_idle_en got=%b want=1", en); end
  endtask

  task automatic test_reset_mid_wait;
    int low, re_n, we_n, err_n; logic [7:0] dd, wd; logic [15:0] as;
    which = 1'b0; addr = 16'hCAFE; ready = 1'b0; req = 1'b1;
    tick;
    req = 1'b0;
    tick; tick;
    #2 rst = 1'b0;
    #1;
    total++; if (en !== 1'b1) begin bad++; $display("FAIL midrst_en got=%b want=1", en); end
    total++; if (din !== 8'h00) begin bad++; $display("FAIL midrst_din got=%h want=00", din); end
    total++; if (maddr !== 16'h0000) begin bad++; $display("FAIL midrst_addr got=%h want=0000", maddr); end
    total++; if ({re, we, err} !== 3'b000) begin bad++; $display("FAIL midrst_strobes got=%b want=000", {re, we, err}); end
    #3 rst = 1'b1;
    tick;
    rdata = 8'h77;
    do_access(1'b0, 16'h4321, 8'h00, 0, low, re_n, we_n, err_n, dd, as, wd);
    total++; if (re_n !== 1) begin bad++; $display("FAIL post_rst_re got=%0d want=1", re_n); end
    total++; if (as !== 16'h4321) begin bad++; $display("FAIL post_rst_addr got=%h want=4321", as); end
    total++; if (low !== 4) begin bad++; $display("FAIL post_rst_stall got=%0d want=4", low); end
    total++; if (dd !== 8'h77) begin bad++; $display("FAIL post_rst_data got=%h want=77", dd); end
  endtask

  initial begin
    test_reset;
    test_read;
    test_write;
    test_late_ready;
    test_timeout;
    test_back_to_back;
    test_reset_mid_wait;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
